// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO behind a single-word memory-mapped port.
// Optional macro UART_RX_IRQ_EN adds a registered irq output.
module uart_rx #(
  parameter int unsigned clks_per_bit = 434,
  parameter int unsigned fifo_depth   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  input  logic        rx
`ifdef UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned cnt_w  = $clog2(clks_per_bit);
  localparam int unsigned addr_w = $clog2(fifo_depth);
  localparam int unsigned ptr_w  = addr_w + 1;

  localparam logic [cnt_w-1:0] cnt_half = cnt_w'(clks_per_bit / 2 - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(clks_per_bit - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       sync;
  logic             rx_s;
  logic [1:0]       state, state_d;
  logic [cnt_w-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             push_c;
  logic             ferr_set_c;

  logic [7:0]       mem [fifo_depth];
  logic [ptr_w-1:0] wp, rp;
  logic             overrun, ferr;
  logic             nonempty_c, full_c;
  logic             is_read_c, sel_status_c;
  logic             pop_c, fifo_wr_c, overrun_set_c, stat_wr_c;
  logic [31:0]      rdata_c;
  logic             unused_ok;

  assign unused_ok = ^{uart_instr, uart_addr[31:3], uart_addr[1:0],
                       uart_wdata[31:3], uart_wdata[0]};

  // Two-flop synchroniser, idle-high out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end

  // Frame deserialiser: mid-bit sampling counted from the start edge
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    shift_d    = shift;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = cnt_half;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
            cnt_d   = cnt_full;
          end
        end else begin
          cnt_d = cnt - cnt_w'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_d[idx] = rx_s;
          cnt_d        = cnt_full;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt - cnt_w'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) push_c     = 1'b1;
          else      ferr_set_c = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - cnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nonempty_c    = (wp != rp);
  assign full_c        = (wp[ptr_w-1] != rp[ptr_w-1]) && (wp[addr_w-1:0] == rp[addr_w-1:0]);
  assign is_read_c     = (uart_wstrb == 4'b0000);
  assign sel_status_c  = uart_addr[2];
  assign pop_c         = uart_valid && is_read_c && !sel_status_c && nonempty_c;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign fifo_wr_c     = push_c && (!full_c || pop_c);
  assign overrun_set_c = push_c && full_c && !pop_c;
  assign stat_wr_c     = uart_valid && !is_read_c && sel_status_c;

  always_comb begin
    rdata_c = '0;
    if (uart_valid && is_read_c) begin
      if (sel_status_c)    rdata_c = {28'b0, full_c, ferr, overrun, nonempty_c};
      else if (nonempty_c) rdata_c = {23'b0, 1'b1, mem[rp[addr_w-1:0]]};
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr_c) mem[wp[addr_w-1:0]] <= shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp         <= '0;
      rp         <= '0;
      overrun    <= 1'b0;
      ferr       <= 1'b0;
      uart_ready <= 1'b0;
      uart_rdata <= '0;
    end else begin
      if (fifo_wr_c) wp <= wp + ptr_w'(1);
      if (pop_c)     rp <= rp + ptr_w'(1);
      // A new error event wins over a simultaneous clear
      if (overrun_set_c)                 overrun <= 1'b1;
      else if (stat_wr_c && uart_wdata[1]) overrun <= 1'b0;
      if (ferr_set_c)                    ferr <= 1'b1;
      else if (stat_wr_c && uart_wdata[2]) ferr <= 1'b0;
      uart_ready <= uart_valid;
      uart_rdata <= rdata_c;
    end
  end

`ifdef UART_RX_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= nonempty_c | overrun | ferr;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized traffic checked against a queue-based model.
module tb_uart_rx;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_valid;
  logic        uart_instr;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        rx;
`ifdef UART_RX_IRQ_EN
  logic        irq;
`endif

  uart_rx #(.clks_per_bit(CPB), .fifo_depth(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .uart_valid(uart_valid),
    .uart_instr(uart_instr),
    .uart_addr (uart_addr),
    .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb),
    .uart_rdata(uart_rdata),
    .uart_ready(uart_ready),
    .rx        (rx)
`ifdef UART_RX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: received bytes, sticky error flags, expected bus responses in issue order
  logic [7:0]  mq[$];
  bit          m_ovr, m_ferr;
  logic [31:0] rsp_q[$];
  logic        vld_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'b0, (mq.size() == DEPTH), m_ferr, m_ovr, (mq.size() != 0)};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) vld_d <= 1'b0;
    else        vld_d <= uart_valid;
  end

  // Every cycle: ready follows valid by one cycle, rdata matches model or is zero
  always @(negedge clock) begin
    if (!reset) begin
      check("reset_ready", {31'b0, uart_ready}, 32'h0);
      check("reset_rdata", uart_rdata, 32'h0);
    end else begin
      check("ready", {31'b0, uart_ready}, {31'b0, vld_d});
      if (vld_d) begin
        if (rsp_q.size() == 0) check("rsp_underflow", 32'h1, 32'h0);
        else                   check("rdata", uart_rdata, rsp_q.pop_front());
      end else begin
        check("rdata_idle", uart_rdata, 32'h0);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus(input bit status, input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd);
    logic [31:0] exp;
    exp = '0;
    if (strb == 4'b0000) begin
      if (status)              exp = m_status();
      else if (mq.size() != 0) exp = {23'b0, 1'b1, mq.pop_front()};
    end else if (status) begin
      if (wd[1]) m_ovr  = 1'b0;
      if (wd[2]) m_ferr = 1'b0;
    end
    rsp_q.push_back(exp);
    uart_valid = 1'b1;
    uart_addr  = status ? 32'h0100_0004 : 32'h0100_0000;
    uart_wstrb = strb;
    uart_wdata = wd;
    uart_instr = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    uart_valid = 1'b0;
    uart_wstrb = 4'b0000;
    uart_wdata = $urandom;
    @(negedge clock);
    rd = uart_rdata;
    @(posedge clock); #1;
  endtask

  task automatic rd_data(output logic [31:0] rd);
    bus(1'b0, 4'b0000, 32'h0, rd);
  endtask

  task automatic rd_status(output logic [31:0] rd);
    bus(1'b1, 4'b0000, 32'h0, rd);
  endtask

  task automatic wr_status(input logic [31:0] wd);
    logic [31:0] rd;
    bus(1'b1, 4'b1111, wd, rd);
  endtask

  // One full 8N1 frame; a bad stop bit is held low past the sampling point then released
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_cycles(CPB);
    end else begin
      rx = 1'b0;
      wait_cycles(12);
      rx = 1'b1;
      wait_cycles(CPB - 12);
    end
    if (!stop_ok)                m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr  = 1'b1;
    else                         mq.push_back(b);
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    wait_cycles(len);
    rx = 1'b1;
    wait_cycles(CPB + 4);
  endtask

`ifdef UART_RX_IRQ_EN
  task automatic check_irq();
    wait_cycles(2);
    check("irq", {31'b0, irq}, {31'b0, (mq.size() != 0) | m_ovr | m_ferr});
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    reset      = 1'b0;
    rx         = 1'b1;
    uart_valid = 1'b0;
    uart_instr = 1'b0;
    uart_addr  = '0;
    uart_wdata = '0;
    uart_wstrb = '0;
    m_ovr      = 1'b0;
    m_ferr     = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(4);

    rd_status(rd);
    check("status_after_reset", rd, 32'h0);

    send_frame(8'hA5, 1'b1);
    rd_data(rd);
    check("a5_read", rd, 32'h0000_01A5);
    rd_data(rd);
    check("a5_second_read", rd, 32'h0);

    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    send_frame(8'h33, 1'b1);
    rd_data(rd); check("b2b_0", rd, 32'h131);
    rd_data(rd); check("b2b_1", rd, 32'h132);
    rd_data(rd); check("b2b_2", rd, 32'h133);
    rd_status(rd); check("b2b_status", rd, 32'h0);

    glitch(6);
    rd_status(rd); check("glitch_status", rd, 32'h0);

    send_frame(8'h55, 1'b0);
    rd_status(rd); check("ferr_status", rd, 32'h4);
`ifdef UART_RX_IRQ_EN
    check_irq();
`endif
    wr_status(32'h4);
    rd_status(rd); check("ferr_cleared", rd, 32'h0);

    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    rd_status(rd); check("full_status", rd, 32'h9);
    send_frame(8'h05, 1'b1);
    rd_status(rd); check("overrun_status", rd, 32'hB);
    for (int i = 1; i <= 4; i++) begin
      rd_data(rd);
      check("fifo_order", rd, 32'h100 | 32'(i));
    end
    rd_data(rd); check("fifo_drained", rd, 32'h0);
`ifdef UART_RX_IRQ_EN
    check_irq();
`endif
    rd_status(rd); check("overrun_sticky", rd, 32'h2);
    wr_status(32'h2);
    rd_status(rd); check("overrun_cleared", rd, 32'h0);

    // Abort frame 0x7E mid bit 3 with reset
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h7E >> i);
      wait_cycles(CPB);
    end
    rx = 1'(8'h7E >> 3);
    wait_cycles(CPB / 2);
    reset = 1'b0;
    rx    = 1'b1;
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(4);
    rd_status(rd); check("midframe_reset_status", rd, 32'h0);
    send_frame(8'h42, 1'b1);
    rd_data(rd); check("after_reset_read", rd, 32'h142);
    rd_data(rd); check("after_reset_empty", rd, 32'h0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          send_frame(8'($urandom), ($urandom_range(0, 9) != 0));
          wait_cycles($urandom_range(0, 20));
        end
        2: begin
          for (int k = 0; k < int'($urandom_range(2, 3)); k++) send_frame(8'($urandom), 1'b1);
        end
        3: glitch($urandom_range(1, 6));
        4: rd_data(rd);
        5: rd_status(rd);
        6: wr_status($urandom);
        default: bus(1'b0, 4'($urandom_range(1, 15)), $urandom, rd);
      endcase
    end
`ifdef UART_RX_IRQ_EN
    check_irq();
`endif

    while (mq.size() != 0) rd_data(rd);
    rd_data(rd); check("final_empty", rd, 32'h0);
    wr_status(32'h6);
    rd_status(rd); check("final_status", rd, 32'h0);
    wait_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
